arb_mux_nx1: RTL and testbench
==============================

ARB_MUX_NX1 -- requirements
Module: arb_mux_nx1

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each data channel.
REQ-002 Parameter NUM_CH, default 4: number of input channels, legal range 1..16.
REQ-003 Parameter RR_MODE, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, lowest index wins.
REQ-004 Localparam CH_W = max(1, clog2(NUM_CH)).
REQ-005 clk  input  1: single clock; all state updates on the rising edge.
REQ-006 rst  input  1: synchronous, active-high reset.
REQ-007 din  input  NUM_CH*DATA_WIDTH: flat channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 din_valid  input  NUM_CH: per-channel request or valid.
REQ-009 din_ready  output  NUM_CH: per-channel accept; at most one bit is high per cycle.
REQ-010 dout  output  DATA_WIDTH: registered selected data.
REQ-011 dout_ch  output  CH_W: registered index of the channel that supplied dout.
REQ-012 dout_valid  output  1: dout and dout_ch hold a valid beat.
REQ-013 dout_ready  input  1: downstream accepts a beat.

Function
REQ-014 A transfer on channel i SHALL occur in a cycle where din_valid[i] && din_ready[i]; an output transfer SHALL occur where dout_valid && dout_ready.
REQ-015 load_en SHALL be (!dout_valid || dout_ready); it is combinational from the register state and dout_ready.
REQ-016 din_ready[i] SHALL be (grant[i] && load_en), where grant is one-hot over valid channels, or zero when no channel is valid.
REQ-017 din_ready SHALL NOT depend on din_valid of channel i itself beyond arbitration.
REQ-018 No valid channel is ever granted while invalid.
REQ-019 Accepted data SHALL appear on dout, and the index on dout_ch, with dout_valid=1, on the next cycle (latency 1).
REQ-020 When dout_valid && !dout_ready, dout, dout_ch and dout_valid SHALL hold stable and all din_ready SHALL be 0.
REQ-021 A simultaneous drain and load SHALL both occur in the same cycle, giving full throughput of 1 beat per cycle.
REQ-022 On a drain with no valid input, dout_valid SHALL fall to 0; dout and dout_ch SHALL retain their last values.
REQ-023 In round-robin mode, the priority pointer ptr SHALL be CH_W bits.
REQ-024 The arbiter SHALL search from ptr upward, wrapping modulo NUM_CH; the first valid channel wins.
REQ-025 ptr SHALL update to (k+1) mod NUM_CH only on an accepted transfer from channel k, and SHALL hold otherwise, including when stalled.
REQ-026 In fixed-priority mode, ptr SHALL be unused, with a constant 0 search start.
REQ-027 With NUM_CH=1, the block SHALL degenerate to a 1-deep pipeline register with dout_ch=0.
REQ-028 With NUM_CH not a power of two, the pointer wrap SHALL skip nonexistent indices.

Reset
REQ-029 When rst=1 at a rising edge, the block SHALL set dout_valid=0, dout=0, dout_ch=0 and ptr=0.
REQ-030 During the reset cycle, din_ready SHALL be all zeros regardless of inputs.
REQ-031 A beat held in the output register at reset assertion SHALL be discarded.
REQ-032 Reset SHALL override a simultaneous load or drain.

Structure
REQ-033 A shared package SHALL hold the clog2-based width helper and the RR_MODE encodings (ARB_FIXED=0, ARB_RR=1).
REQ-034 Sub-module rr_arbiter SHALL contain the combinational grant logic plus the ptr register.
REQ-035 rr_arbiter SHALL take req, adv (the accept strobe), clk and rst, and SHALL output a one-hot grant.
REQ-036 The data selection SHALL be a one-hot AND-OR mux in the top level.

Verification
REQ-037 Reset: assert rst while dout_valid=1 -> next cycle dout_valid=0, dout=0, dout_ch=0, din_ready=0000.
REQ-038 Round-robin fairness, NUM_CH=4: all valid, dout_ready=1 constantly -> dout_ch sequence 0,1,2,3,0 with one beat per cycle.
REQ-039 Backpressure: load ch2 data 0xDEADBEEF, then hold dout_ready=0 for 5 cycles -> dout stays 0xDEADBEEF, dout_ch stays 2, din_ready stays 0000, ptr stays 3.
REQ-040 Wrap and skip: ptr=3, din_valid=0101 -> ch0 granted, ptr becomes 1; next grant goes to ch2.
REQ-041 Fixed priority, RR_MODE=0: din_valid=1010 held -> ch1 wins every cycle and ch3 is never granted.
REQ-042 NUM_CH=3 wrap: ptr=2 and ch2 accepted -> ptr becomes 0, not 3.

Source files
------------

// File: rtl/arb_mux_nx1_pkg.sv
// Shared constants and width helpers for the N:1 arbitrated output mux.
package arb_mux_nx1_pkg;

    // Arbitration mode encodings.
    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // Largest supported channel count.
    localparam int unsigned MAX_CH    = 16;

    // Ceiling log2 for elaboration-time width computation.
    function automatic int unsigned clog2_u(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Channel index width; never narrower than one bit so NUM_CH=1 still has a port.
    function automatic int unsigned ch_width(input int unsigned n);
        int unsigned w;
        w = clog2_u(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/arb_mux_nx1_rr_arbiter.sv
// Grant generator: one-hot grant over requesting channels, searching from a
// rotating priority pointer (round-robin) or from index 0 (fixed priority).
module rr_arbiter
    import arb_mux_nx1_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned RR_MODE = ARB_RR,
    localparam int unsigned CH_W   = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              adv,
    output logic [NUM_CH-1:0] grant
);

    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] ptr_next;
    logic [CH_W-1:0] win_idx;
    logic            found;
    int unsigned     start_idx;
    int unsigned     cand;
    int unsigned     win_plus;

    // Scan from the start point upward with wrap; the first requester wins.
    always_comb begin
        grant     = '0;
        win_idx   = '0;
        found     = 1'b0;
        cand      = 0;
        start_idx = (RR_MODE == ARB_RR) ? 32'(ptr) : 32'd0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            cand = start_idx + off;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                win_idx     = CH_W'(cand);
            end
        end
        // Pointer moves one past the winner, wrapping at NUM_CH so unused codes are skipped.
        win_plus = 32'(win_idx) + 32'd1;
        ptr_next = (win_plus >= NUM_CH) ? '0 : CH_W'(win_plus);
    end

    // Priority pointer: advances only on an accepted transfer in round-robin mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if ((RR_MODE == ARB_RR) && adv && found) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/arb_mux_nx1.sv
// N:1 arbitrated mux with a single registered output stage and valid/ready
// handshakes on both sides; sustains one beat per cycle.
module arb_mux_nx1
    import arb_mux_nx1_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned RR_MODE    = ARB_RR,
    localparam int unsigned CH_W      = ch_width(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] din,
    input  logic [NUM_CH-1:0]            din_valid,
    output logic [NUM_CH-1:0]            din_ready,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic [CH_W-1:0]              dout_ch,
    output logic                         dout_valid,
    input  logic                         dout_ready
);

    logic [NUM_CH-1:0]     grant;
    logic                  load_en;
    logic                  accept;
    logic                  any_grant;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [CH_W-1:0]       sel_ch;

    // Output register can take a new beat when empty or being drained this cycle.
    assign load_en   = !dout_valid || dout_ready;
    assign accept    = load_en && !rst;
    assign any_grant = |grant;
    assign din_ready = accept ? grant : '0;

    rr_arbiter #(
        .NUM_CH  (NUM_CH),
        .RR_MODE (RR_MODE)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (din_valid),
        .adv   (accept),
        .grant (grant)
    );

    // One-hot AND-OR selection of the granted channel's data and index.
    always_comb begin
        sel_data = '0;
        sel_ch   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sel_data = sel_data | (din[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
            if (grant[i]) begin
                sel_ch = sel_ch | CH_W'(i);
            end
        end
    end

    // Output stage: load on accept, drop valid on a drain with nothing to load, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout       <= '0;
            dout_ch    <= '0;
        end else if (load_en) begin
            if (any_grant) begin
                dout_valid <= 1'b1;
                dout       <= sel_data;
                dout_ch    <= sel_ch;
            end else begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux_nx1.sv
// Self-checking bench: four configurations (4ch RR, 4ch fixed, 3ch RR, 1ch)
// compared every cycle against a queue-free behavioural model of the arbiter.
module tb_arb_mux_nx1;

    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int nch [NI] = '{4, 4, 3, 1};
    int rr  [NI] = '{1, 0, 1, 1};

    logic [31:0] dw  [NI][16];
    logic [15:0] vv  [NI];
    logic        rdy [NI];

    logic [31:0] m_data  [NI];
    logic        m_valid [NI];
    int          m_ch    [NI];
    int          m_ptr   [NI];

    logic [15:0] obs_ready [NI];
    logic [31:0] obs_dout  [NI];
    logic [31:0] obs_ch    [NI];
    logic [31:0] obs_ptr   [NI];
    logic        obs_valid [NI];

    int n_cmp = 0;
    int n_bad = 0;

    logic [127:0] din_a, din_b;
    logic [95:0]  din_c;
    logic [31:0]  din_d;
    logic [3:0]   dr_a, dr_b;
    logic [2:0]   dr_c;
    logic [0:0]   dr_d;
    logic [31:0]  dout_a, dout_b, dout_c, dout_d;
    logic [1:0]   dch_a, dch_b, dch_c;
    logic [0:0]   dch_d;
    logic         dov_a, dov_b, dov_c, dov_d;

    assign din_a = {dw[0][3], dw[0][2], dw[0][1], dw[0][0]};
    assign din_b = {dw[1][3], dw[1][2], dw[1][1], dw[1][0]};
    assign din_c = {dw[2][2], dw[2][1], dw[2][0]};
    assign din_d = dw[3][0];

    arb_mux_nx1 #(.DATA_WIDTH(32), .NUM_CH(4), .RR_MODE(1)) u_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(vv[0][3:0]), .din_ready(dr_a),
        .dout(dout_a), .dout_ch(dch_a), .dout_valid(dov_a), .dout_ready(rdy[0]));
    arb_mux_nx1 #(.DATA_WIDTH(32), .NUM_CH(4), .RR_MODE(0)) u_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(vv[1][3:0]), .din_ready(dr_b),
        .dout(dout_b), .dout_ch(dch_b), .dout_valid(dov_b), .dout_ready(rdy[1]));
    arb_mux_nx1 #(.DATA_WIDTH(32), .NUM_CH(3), .RR_MODE(1)) u_c (
        .clk(clk), .rst(rst), .din(din_c), .din_valid(vv[2][2:0]), .din_ready(dr_c),
        .dout(dout_c), .dout_ch(dch_c), .dout_valid(dov_c), .dout_ready(rdy[2]));
    arb_mux_nx1 #(.DATA_WIDTH(32), .NUM_CH(1), .RR_MODE(1)) u_d (
        .clk(clk), .rst(rst), .din(din_d), .din_valid(vv[3][0:0]), .din_ready(dr_d),
        .dout(dout_d), .dout_ch(dch_d), .dout_valid(dov_d), .dout_ready(rdy[3]));

    assign obs_ready[0] = 16'(dr_a);
    assign obs_ready[1] = 16'(dr_b);
    assign obs_ready[2] = 16'(dr_c);
    assign obs_ready[3] = 16'(dr_d);
    assign obs_dout[0]  = dout_a;
    assign obs_dout[1]  = dout_b;
    assign obs_dout[2]  = dout_c;
    assign obs_dout[3]  = dout_d;
    assign obs_ch[0]    = 32'(dch_a);
    assign obs_ch[1]    = 32'(dch_b);
    assign obs_ch[2]    = 32'(dch_c);
    assign obs_ch[3]    = 32'(dch_d);
    assign obs_valid[0] = dov_a;
    assign obs_valid[1] = dov_b;
    assign obs_valid[2] = dov_c;
    assign obs_valid[3] = dov_d;
    assign obs_ptr[0]   = 32'(u_a.u_arb.ptr);
    assign obs_ptr[1]   = 32'(u_b.u_arb.ptr);
    assign obs_ptr[2]   = 32'(u_c.u_arb.ptr);
    assign obs_ptr[3]   = 32'(u_d.u_arb.ptr);

    // Winner: first valid channel at or after the start point, wrapping over n channels.
    function automatic int pick(input int n, input int r, input int p, input logic [15:0] v);
        int s;
        s = (r != 0) ? p : 0;
        for (int o = 0; o < n; o++) begin
            if (v[(s + o) % n]) return (s + o) % n;
        end
        return -1;
    endfunction

    function automatic logic [15:0] mask_of(input int n);
        logic [31:0] m;
        m = (32'd1 << n) - 32'd1;
        return m[15:0];
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, i, obs, exp);
        end
    endtask

    // One clock: compare all instances mid-cycle, advance the model, return just after the edge.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            int          idx;
            logic        ld;
            logic [15:0] er;
            idx = pick(nch[i], rr[i], m_ptr[i], vv[i]);
            ld  = !m_valid[i] || rdy[i];
            er  = '0;
            if (!rst && ld && idx >= 0) er[idx] = 1'b1;
            chk("din_ready",  i, 32'(obs_ready[i]), 32'(er));
            chk("dout_valid", i, 32'(obs_valid[i]), 32'(m_valid[i]));
            chk("dout",       i, obs_dout[i], m_data[i]);
            chk("dout_ch",    i, obs_ch[i], 32'(m_ch[i]));
            chk("ptr",        i, obs_ptr[i], 32'(m_ptr[i]));
            if (rst) begin
                m_valid[i] = 1'b0;
                m_data[i]  = '0;
                m_ch[i]    = 0;
                m_ptr[i]   = 0;
            end else if (ld) begin
                if (idx >= 0) begin
                    m_valid[i] = 1'b1;
                    m_data[i]  = dw[i][idx];
                    m_ch[i]    = idx;
                    if (rr[i] != 0) m_ptr[i] = (idx + 1) % nch[i];
                end else begin
                    m_valid[i] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            vv[i]      = '0;
            rdy[i]     = 1'b1;
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
            m_ch[i]    = 0;
            m_ptr[i]   = 0;
            for (int j = 0; j < 16; j++) dw[i][j] = $urandom;
        end
        step();
        step();

        // Load a beat and stall it, then reset on top of it.
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            vv[i]  = mask_of(nch[i]);
            rdy[i] = 1'b0;
        end
        step();
        step();
        chk("pre_rst_valid", 0, 32'(obs_valid[0]), 32'd1);
        rst = 1'b1;
        step();
        chk("rst_valid", 0, 32'(obs_valid[0]), 32'd0);
        chk("rst_dout",  0, obs_dout[0], 32'd0);
        chk("rst_ch",    0, obs_ch[0], 32'd0);
        chk("rst_ready", 0, 32'(obs_ready[0]), 32'd0);
        rst = 1'b0;

        // Round-robin fairness, fixed priority and 3-channel rotation in parallel.
        vv[0] = 16'hF;
        vv[1] = 16'hA;
        vv[2] = 16'h7;
        vv[3] = 16'h1;
        for (int i = 0; i < NI; i++) rdy[i] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_seq",    0, obs_ch[0], 32'(k % 4));
            chk("rr_valid",  0, 32'(obs_valid[0]), 32'd1);
            chk("fixed_ch",  1, obs_ch[1], 32'd1);
            chk("fixed_no3", 1, 32'(obs_ready[1][3]), 32'd0);
            chk("rr3_seq",   2, obs_ch[2], 32'(k % 3));
        end

        // Backpressure on a ch2 beat; 3-channel pointer wraps 2 -> 0.
        dw[0][2] = 32'hDEADBEEF;
        vv[0]    = 16'h4;
        vv[2]    = 16'h4;
        step();
        chk("rr3_wrap_ptr", 2, obs_ptr[2], 32'd0);
        chk("bp_ptr0",      0, obs_ptr[0], 32'd3);
        rdy[0] = 1'b0;
        vv[0]  = 16'hF;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_dout",  0, obs_dout[0], 32'hDEADBEEF);
            chk("bp_ch",    0, obs_ch[0], 32'd2);
            chk("bp_ready", 0, 32'(obs_ready[0]), 32'd0);
            chk("bp_ptr",   0, obs_ptr[0], 32'd3);
        end

        // Wrap and skip from ptr=3 with channels 0 and 2 valid.
        rdy[0] = 1'b1;
        vv[0]  = 16'h5;
        step();
        chk("wrap_ch",  0, obs_ch[0], 32'd0);
        chk("wrap_ptr", 0, obs_ptr[0], 32'd1);
        step();
        chk("skip_ch",  0, obs_ch[0], 32'd2);
        chk("skip_ptr", 0, obs_ptr[0], 32'd3);

        // Randomised traffic with occasional resets.
        for (int t = 0; t < 400; t++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < NI; i++) begin
                vv[i]  = 16'($urandom) & mask_of(nch[i]);
                rdy[i] = ($urandom_range(0, 3) != 0);
                for (int j = 0; j < 16; j++) dw[i][j] = $urandom;
            end
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
